fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline. Owns the PC and issues in-order word requests to instruction memory.
- Buffers returned instructions in a small FIFO and presents them, with their PC, to decode. Decode's immediate extender and register-file read consume these.
- Handles EX-stage redirects (taken branch, JAL, JALR) by flushing buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- DEPTH, 2, instruction buffer entries (>=2). Also the maximum of outstanding requests plus buffered entries.

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  response valid; cannot be back-pressured
- imem_rsp_data  in  32  returned instruction word
- redirect_valid  in  1  EX-stage redirect (branch taken or jump)
- redirect_pc  in  32  redirect target
- id_valid  out  1  instruction available to decode
- id_ready  in  1  decode accepts (low = ID stall)
- id_inst  out  32  instruction to decode
- id_pc  out  32  PC of id_inst

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high.
- Reset values:
  - pc and resp_pc are set to RESET_PC.
  - Buffer count, outstanding count and drop count are set to 0.
  - While rst is high: imem_req_valid=0, id_valid=0, id_inst=32'h0000_0013 (NOP), id_pc=0.
- Empty buffer: id_valid=0, id_inst=NOP, id_pc=0.
- Request issue:
  - imem_req_addr = pc, with bits [1:0] always 0.
  - imem_req_valid = !rst && !redirect_valid && (outstanding + count < DEPTH + pop), where pop = id_valid && id_ready.
  - Request accepted when imem_req_valid && imem_req_ready. Then pc <= pc+4 (wraps modulo 2^32) and outstanding increments.
  - imem_req_valid may drop without a handshake (address is stable while valid and not redirected).
- Response:
  - Responses return in order, at least 1 cycle after acceptance.
  - Each imem_rsp_valid decrements outstanding.
  - If drop>0, the response is discarded and drop decrements.
  - Otherwise {resp_pc, imem_rsp_data} is pushed and resp_pc <= resp_pc+4.
  - A response with outstanding==0 (stale across reset) is ignored.
  - The credit rule guarantees a push never finds the buffer full. Overflow is an assertion failure.
- Decode interface:
  - id_valid = (count>0) && !redirect_valid. id_inst/id_pc come from the buffer head.
  - Pop on id_valid && id_ready. Head holds stable while id_ready=0.
- Latency and throughput:
  - Response in cycle N gives id_valid in cycle N+1.
  - With 1-cycle memory and id_ready=1: first id_valid 2 cycles after rst deasserts, then 1 instruction/cycle.
- Redirect (top priority, single cycle):
  - pc <= {redirect_pc[31:2],2'b00}; resp_pc <= the same value.
  - Buffer is flushed (count<=0).
  - drop <= outstanding after this cycle's decrement, i.e. all in-flight responses not already consumed.
  - No request is issued and no pop occurs that cycle. A response arriving that cycle is discarded.
  - Fetch from the target begins the next cycle.
  - A second redirect while drop>0 reloads pc. drop takes the new outstanding value, so the old drop residue is still correctly counted.
- Simultaneous push and pop: count unchanged. Push into an empty buffer with pop is impossible, since id_valid needs count>0.
- Counter widths: $clog2(DEPTH+1) bits for count, outstanding and drop.

Test Plan:
- Reset, 1-cycle memory returning addr-derived data, id_ready=1:
  - Requests at 0x0, 0x4, 0x8... on consecutive cycles.
  - id_valid first 2 cycles after reset; id_pc/id_inst pairs 0x0, 0x4, 0x8 in order, one per cycle.
- id_ready=0 for 5 cycles mid-stream:
  - Buffer fills to DEPTH; imem_req_valid drops; head id_pc held.
  - No lost or duplicated PC on release.
- 3-cycle memory latency with DEPTH=2: outstanding never exceeds 2, and the id_pc sequence stays contiguous.
- redirect_valid with redirect_pc=0x0000_0103 while 2 requests are in flight:
  - id_valid=0 in the redirect cycle; both stale responses are dropped.
  - Next fetch address 0x100; next id_pc=0x100.
- Two redirects 1 cycle apart (targets 0x200, then 0x300) with in-flight responses: only instructions from 0x300 onward reach decode.
- rst asserted mid-stream with one response still arriving afterwards: the stale response is ignored, and fetch restarts at RESET_PC with id_pc=RESET_PC first.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order word fetches under a
// credit limit, buffers returned words with their PC, and hands them to decode.
// An EX-stage redirect flushes the buffer and drops every in-flight response.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  localparam int          CW  = $clog2(DEPTH + 1);
  localparam int          PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   r_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [31:0]   r_buf_inst [DEPTH];
  logic [31:0]   r_buf_pc   [DEPTH];

  logic [31:0]   w_redirect_target;
  logic [CW:0]   w_used;
  logic [CW:0]   w_limit;
  logic          w_pop;
  logic          w_accept;
  logic          w_rsp_take;
  logic          w_push;
  logic [PW-1:0] w_rd_ptr_inc;
  logic [PW-1:0] w_wr_ptr_inc;

  assign w_redirect_target = redirect_pc & ~32'h0000_0003;

  // Request credit counts both in-flight fetches and buffered words, so a
  // response can always be pushed without back-pressuring memory.
  assign w_used  = (CW+1)'(r_outstanding) + (CW+1)'(r_count);
  assign w_limit = (CW+1)'(DEPTH) + (CW+1)'(w_pop);

  assign w_rd_ptr_inc = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
  assign w_wr_ptr_inc = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);

  // Handshake and datapath decode for the current cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    id_valid       = 1'b0;
    id_inst        = NOP;
    id_pc          = 32'h0;
    imem_req_valid = 1'b0;
    imem_req_addr  = r_pc & ~32'h0000_0003;

    id_valid = !rst && (r_count != '0) && !redirect_valid;
    if (id_valid) begin
      id_inst = r_buf_inst[r_rd_ptr];
      id_pc   = r_buf_pc[r_rd_ptr];
    end

    imem_req_valid = !rst && !redirect_valid && (w_used < w_limit);
  end

  assign w_pop      = id_valid && id_ready;
  assign w_accept   = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding belongs to a fetch issued before reset.
  assign w_rsp_take = imem_rsp_valid && (r_outstanding != '0);
  assign w_push     = w_rsp_take && (r_drop == '0) && !redirect_valid;

  // PC, response PC, occupancy, in-flight and drop bookkeeping.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_rsp_take);
      if (redirect_valid) begin
        r_pc      <= w_redirect_target;
        r_resp_pc <= w_redirect_target;
        r_count   <= '0;
        r_rd_ptr  <= '0;
        r_wr_ptr  <= '0;
        // Everything still in flight after this cycle's response is stale.
        r_drop    <= r_outstanding - CW'(w_rsp_take);
      end else begin
        if (w_accept) r_pc <= r_pc + 32'd4;
        if (w_rsp_take && (r_drop != '0)) r_drop <= r_drop - CW'(1);
        if (w_push) begin
          r_resp_pc <= r_resp_pc + 32'd4;
          r_wr_ptr  <= w_wr_ptr_inc;
        end
        if (w_pop) r_rd_ptr <= w_rd_ptr_inc;
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Instruction buffer storage, written on push.
  // NOTE: the storage array is not reset; occupancy is tracked by r_count, so
  // stale entries are never presented and resetting them would only cost area.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_inst[r_wr_ptr] <= imem_rsp_data;
      r_buf_pc[r_wr_ptr]   <= r_resp_pc;
    end
  end

  // The credit rule must make a push into a full buffer impossible.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(w_push && (r_count == CW'(DEPTH)) && !w_pop));
  end

endmodule
